// File: rtl/fp8_operand_loader.sv
// Operand-pair feeder for the FP8 multiplier: synchronizes a pin strobe,
// assembles A/B byte pairs and queues them in a small FIFO with valid/ready output.
module fp8_operand_loader #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_byte,
  input  logic                       in_strobe,
  input  logic                       flush,
  output logic [WIDTH-1:0]           op_a,
  output logic [WIDTH-1:0]           op_b,
  output logic                       op_valid,
  input  logic                       op_ready,
  output logic                       phase,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             cap;
  logic [WIDTH-1:0] hold_a_q, hold_a_d;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push_try, push_ok, pop;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= in_strobe;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign cap = s2_q & ~s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_A;
      hold_a_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_a_q <= hold_a_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_a_d = hold_a_q;
    push_try = 1'b0;
    if (flush) begin
      state_d = WAIT_A;
    end else if (cap) begin
      case (state_q)
        WAIT_A: begin
          hold_a_d = in_byte;
          state_d  = WAIT_B;
        end
        WAIT_B: begin
          push_try = 1'b1;
          state_d  = WAIT_A;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  assign op_valid = (count_q != '0);
  assign pop      = op_valid & op_ready & ~flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_try & ((count_q < FULL_COUNT) | pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_try && !push_ok) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_a_q[wr_ptr_q] <= hold_a_q;
      mem_b_q[wr_ptr_q] <= in_byte;
    end
  end

  assign op_a     = mem_a_q[rd_ptr_q];
  assign op_b     = mem_b_q[rd_ptr_q];
  assign phase    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp8_operand_loader.sv
// Directed self-checking bench for fp8_operand_loader (DEPTH=2, WIDTH=8).
module tb_fp8_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_strobe;
  logic       flush;
  logic [7:0] op_a, op_b;
  logic       op_valid;
  logic       op_ready;
  logic       phase;
  logic [1:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fp8_operand_loader #(.DEPTH(2), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_strobe(in_strobe),
    .flush(flush), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .op_ready(op_ready), .phase(phase), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // side: 0 plain, 1 op_ready in cap cycle, 2 flush in cap cycle, 3 check op_valid latency
  task automatic strobe_side(input logic [7:0] b, input int side);
    @(negedge clk);
    in_byte   = b;
    in_strobe = 1'b1;
    @(negedge clk);               // edge k passed
    @(negedge clk);               // edge k+1 passed: cap cycle
    if (side == 1) op_ready = 1'b1;
    if (side == 2) flush = 1'b1;
    if (side == 3) check("valid_before_k2", op_valid, 0);
    @(negedge clk);               // edge k+2 passed
    if (side == 3) check("valid_at_k2", op_valid, 1);
    op_ready  = 1'b0;
    flush     = 1'b0;
    in_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_pair(input logic [7:0] a, input logic [7:0] b);
    strobe_side(a, 0);
    strobe_side(b, 0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_byte = '0; in_strobe = 1'b0; flush = 1'b0; op_ready = 1'b0;
    #1;
    check("init_phase", phase, 0);
    check("init_count", count, 0);
    check("init_valid", op_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic pair
    strobe_side(8'h38, 0);
    check("basic_phase_after_a", phase, 1);
    strobe_side(8'h40, 3);
    check("basic_op_a", op_a, 8'h38);
    check("basic_op_b", op_b, 8'h40);
    check("basic_count", count, 1);
    check("basic_phase_after_b", phase, 0);
    repeat (3) @(negedge clk);
    check("basic_hold_a", op_a, 8'h38);
    pop_one();
    check("basic_pop_valid", op_valid, 0);
    check("basic_pop_count", count, 0);

    // Held strobe: one capture only
    @(negedge clk);
    in_byte = 8'h11; in_strobe = 1'b1;
    repeat (20) @(negedge clk);
    in_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("held_phase", phase, 1);
    check("held_count", count, 0);
    check("held_valid", op_valid, 0);

    // Overflow
    do_flush();
    check("flush_phase", phase, 0);
    write_pair(8'h01, 8'h02);
    write_pair(8'h03, 8'h04);
    write_pair(8'h05, 8'h06);
    check("ovf_count", count, 2);
    check("ovf_flag", overflow, 1);
    check("ovf_head_a", op_a, 8'h01);
    check("ovf_head_b", op_b, 8'h02);
    pop_one();
    check("ovf_pop1_a", op_a, 8'h03);
    check("ovf_pop1_b", op_b, 8'h04);
    check("ovf_pop1_count", count, 1);
    pop_one();
    check("ovf_pop2_valid", op_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous push and pop
    do_flush();
    check("full_ovf_cleared", overflow, 0);
    write_pair(8'h01, 8'h02);
    write_pair(8'h03, 8'h04);
    check("full_count", count, 2);
    strobe_side(8'h05, 0);
    strobe_side(8'h06, 1);
    check("full_no_ovf", overflow, 0);
    check("full_count_kept", count, 2);
    check("full_head_a", op_a, 8'h03);
    check("full_head_b", op_b, 8'h04);
    pop_one();
    check("full_next_a", op_a, 8'h05);
    check("full_next_b", op_b, 8'h06);
    pop_one();
    check("full_empty", op_valid, 0);

    // Flush mid-pair, coincident with cap
    write_pair(8'h0A, 8'h0B);
    write_pair(8'h0C, 8'h0D);
    write_pair(8'h0E, 8'h0F);
    pop_one();
    strobe_side(8'h7F, 0);
    check("fl_pre_phase", phase, 1);
    check("fl_pre_count", count, 1);
    check("fl_pre_ovf", overflow, 1);
    strobe_side(8'h99, 2);
    check("fl_phase", phase, 0);
    check("fl_count", count, 0);
    check("fl_ovf", overflow, 0);
    check("fl_valid", op_valid, 0);
    write_pair(8'h22, 8'h33);
    check("fl_after_a", op_a, 8'h22);
    check("fl_after_b", op_b, 8'h33);
    check("fl_after_count", count, 1);

    // Asynchronous reset mid-operation
    strobe_side(8'h44, 0);
    check("rst_pre_phase", phase, 1);
    check("rst_pre_count", count, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_phase", phase, 0);
    check("rst_count", count, 0);
    check("rst_valid", op_valid, 0);
    check("rst_op_a", op_a, 8'h00);
    check("rst_op_b", op_b, 8'h00);
    check("rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp8_operand_loader.md
# fp8_operand_loader

Upstream feeder for the FP8 multiplier. Assembles operand pairs (A then B) from a byte-wide pin bus qualified by an asynchronous strobe, queues complete pairs in a small FIFO, and presents them to the multiplier with a valid/ready handshake. It decouples slow, human- or MCU-driven pin writes from the multiplier's acceptance timing.

## Interface

Parameters:
- `DEPTH`, default 2: FIFO depth in operand pairs. Must be a power of 2 and at least 2.
- `WIDTH`, default 8: operand width in bits.

Ports:
- `clk` input 1: the single clock; all state is clocked on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_byte` input WIDTH: operand byte from pins.
- `in_strobe` input 1: asynchronous write strobe from a pin. Its rising edge requests capture of `in_byte`.
- `flush` input 1: synchronous single-cycle clear.
- `op_a` output WIDTH: operand A of the FIFO head entry.
- `op_b` output WIDTH: operand B of the FIFO head entry.
- `op_valid` output 1: the FIFO head entry is valid.
- `op_ready` input 1: the multiplier accepts the head entry.
- `phase` output 1: 0 while waiting for A, 1 while waiting for B.
- `count` output $clog2(DEPTH+1): number of queued pairs.
- `overflow` output 1: sticky flag, set when a pair is dropped because the FIFO was full.

## Operation

**Strobe conditioning**
- `in_strobe` passes through a 2-flop synchronizer (`s1`, `s2`), then a delay flop (`s3`).
- `cap = s2 & ~s3`, giving one pulse per rising edge of the strobe.
- A strobe held high produces exactly one `cap`. The strobe must be low for at least 2 cycles before the next rising edge counts.

**Capture state machine**
- States: WAIT_A (`phase`=0) and WAIT_B (`phase`=1).
- WAIT_A, on `cap`: `hold_a` <= `in_byte`, then go to WAIT_B.
- WAIT_B, on `cap`: attempt to push {`hold_a`, `in_byte`}, then go to WAIT_A whether or not the push succeeds.
- The state is unchanged in any cycle without `cap`.

**FIFO**
- Circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus `count`.
- `pop` = `op_valid` & `op_ready`.
- `push_ok` = push attempt & (`count` < DEPTH | `pop`). A full FIFO accepts a push in the same cycle as a pop.
- Push attempt with `count` == DEPTH and no pop: the pair is discarded, `overflow` <= 1, and all FIFO state is unchanged.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance.
- `op_valid` = (`count` != 0).
- `op_a`/`op_b` show the head entry combinationally from the storage array.
- `op_a`/`op_b` hold their value while `op_valid`=1 and `op_ready`=0. The multiplier may rely on this.

**Flush**
- `flush`=1 has priority over every other event in that cycle.
- State goes to WAIT_A, `count` <= 0, pointers <= 0, `overflow` <= 0.
- A `cap` or `pop` coincident with `flush` is ignored.
- Storage contents are not cleared.

**Reset**
- Asynchronous; takes effect immediately, mid-transfer included.
- `phase`=0, `count`=0, `op_valid`=0, `overflow`=0.
- `op_a`=`op_b`=0, because the storage array and `hold_a` are reset to 0.
- Synchronizer flops reset to 0. A strobe already high when reset is released therefore produces one `cap` 2 cycles after release.

## Timing

- Strobe first sampled high at clock edge k: `s1`=1 after k, `s2`=1 after k+1, `cap` is active in the cycle after k+1, and the byte is captured at edge k+2.
- `in_byte` must be stable from edge k through edge k+2.
- B captured at edge m: the pair is written at edge m, and `op_valid`=1 with correct `op_a`/`op_b` in the cycle after edge m.
- Strobe rising edge for B to `op_valid`: 3 clock edges.
- Pop at edge p: the next entry (or `op_valid`=0) is visible after edge p.
- Throughput: 1 pop per cycle while entries are available.
- `overflow` is set at the edge of the dropped push and stays set until `flush` or `rst`.

## Test plan

1. **Reset defaults:** assert `rst` mid-operation, with `phase`=1 and `count`=1. Required: immediately `phase`=0, `count`=0, `op_valid`=0, `op_a`=`op_b`=0x00, `overflow`=0.
2. **Basic pair:** `op_ready`=0; strobe `in_byte`=0x38, then 0x40. Required: `op_valid`=1 exactly 3 edges after the second strobe's first sampled-high edge, `op_a`=0x38, `op_b`=0x40, `count`=1. Then `op_ready`=1 for 1 cycle: `op_valid`=0, `count`=0.
3. **Held strobe:** hold `in_strobe` high for 20 cycles with `in_byte`=0x11. Required: exactly one capture, `phase`=1. No pair is pushed and `count` stays 0.
4. **Overflow:** DEPTH=2, `op_ready`=0; write pairs (0x01,0x02), (0x03,0x04), (0x05,0x06). Required: `count`=2, `overflow`=1, head (0x01,0x02). Pop twice: (0x03,0x04) then `op_valid`=0. The third pair is never observed.
5. **Full with simultaneous push and pop:** FIFO full; assert `op_ready` in the exact cycle the third pair's `cap` (B byte) occurs. Required: no overflow, `count` remains 2, and pop order is 0x03/0x04 then 0x05/0x06. This also exercises pointer wrap-around.
6. **Flush mid-pair:** capture A=0x7F (`phase`=1), with `count`=1 and `overflow`=1; pulse `flush` coincident with a `cap`. Required: `phase`=0, `count`=0, `overflow`=0, `op_valid`=0. A following pair (0x22,0x33) appears as `op_a`=0x22, `op_b`=0x33.
